// File: rtl/rr_arb_defs_pkg.sv
// rtl/rr_arb_defs_pkg.sv - shared state, requester and sizing definitions for rr_mux_arbiter
package rr_arb_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int NREQ = 4;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  // Hold counter width: clog2(hold_max), never narrower than one bit.
  function automatic int cnt_width(input int hold_max);
    int w;
    w = $clog2(hold_max);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder, search starts at ptr+1 and wraps
module rr_pick
  import rr_arb_defs::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] mask,
  output logic       found,
  output logic [1:0] idx
);

  logic [3:0] eff;
  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    eff   = req & ~mask;
    // Offset NREQ lands back on ptr itself, so the last owner is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + 2'(k);
      if (!found && eff[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin grant FSM and 4:1 data mux
// Optional hold timeout enabled by defining RR_ARB_TIMEOUT_EN.
module rr_mux_arbiter
  import rr_arb_defs::*;
#(
  parameter int DW       = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_b,
  input  logic [DW-1:0] din_c,
  input  logic [DW-1:0] din_d,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] y,
  output logic          y_valid
);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q;
  logic [3:0] pick_mask;
  logic       found;
  logic [1:0] idx;
  logic       owner_req;
  logic       release_a;
  logic       release_b;
  logic       cnt_restart;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .mask  (pick_mask),
    .found (found),
    .idx   (idx)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(HOLD_MAX);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_restart) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign release_b = (state_q == ST_GRANT) && owner_req && (cnt_q == CNT_W'(HOLD_MAX - 1));
`else
  // Without the counter the owner keeps the grant until its request drops.
  logic unused_cfg;
  assign unused_cfg = ^{32'(HOLD_MAX), cnt_restart};
  assign release_b  = 1'b0;
`endif

  assign owner_req = req[sel_q];
  assign release_a = (state_q == ST_GRANT) && !owner_req;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    cnt_restart = 1'b1;
    pick_mask   = 4'b0000;
    // A voluntary release masks the owner; a timeout lets it win again if alone.
    if (release_a) begin
      pick_mask = 4'b0001 << sel_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          sel_d   = idx;
          ptr_d   = idx;
        end
      end
      ST_GRANT: begin
        if (release_a || release_b) begin
          if (found) begin
            sel_d = idx;
            ptr_d = idx;
          end else begin
            state_d = ST_IDLE;
            sel_d   = REQ_A;
          end
        end else begin
          cnt_restart = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = REQ_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= REQ_D;
      sel_q   <= REQ_A;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= (state_d == ST_GRANT) ? (4'b0001 << sel_d) : 4'b0000;
    end
  end

  always_comb begin
    y = '0;
    if (|gnt_q) begin
      case (sel_q)
        REQ_A:   y = din_a;
        REQ_B:   y = din_b;
        REQ_C:   y = din_c;
        default: y = din_d;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign y_valid = |gnt_q;

endmodule
